prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 25 ++
 rtl/word_assembler.sv | 43 ++++
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the program loader:
//                FSM state encoding, bus widths and default limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int c_addr_w        = 32;
    localparam int c_data_w        = 32;
    localparam int c_cnt_w         = 11;
    localparam int c_def_max_words = 1024;
    localparam int c_def_timeout   = 65535;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Packs accepted bytes little-endian into a 32-bit word and
//                flags the acceptance that completes the word.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                accept,
    input  logic [7:0]          byte_in,
    output logic [c_data_w-1:0] word,
    output logic                word_full
);

    logic [1:0]          r_byte_idx;
    logic [c_data_w-1:0] r_word;

    // Byte lane write and lane pointer; clear discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx <= 2'd0;
            r_word     <= '0;
        end else if (clear) begin
            r_byte_idx <= 2'd0;
            r_word     <= '0;
        end else if (accept) begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= byte_in;
            r_byte_idx                        <= r_byte_idx + 2'd1;
        end
    end

    // Asserted in the cycle the fourth byte is taken, so the FSM can move on
    // at the same edge the word becomes complete.
    assign word_full = accept && !clear && (r_byte_idx == 2'd3);
    assign word      = r_word;

endmodule : word_assembler
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Streams program bytes into instruction memory one 32-bit
//                word at a time while holding the CPU, with length checking
//                and an inter-byte idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int                  MAX_WORDS = c_def_max_words,
    parameter int                  TIMEOUT   = c_def_timeout,
    parameter logic [c_addr_w-1:0] BASE_ADDR = 32'h0
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [c_cnt_w-1:0]  word_count,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic                LDwenable,
    output logic [c_addr_w-1:0] LDaddress,
    output logic [c_data_w-1:0] LDdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error
);

    state_t              r_state;
    state_t              w_next;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  r_index;
    logic [c_cnt_w-1:0]  w_index_inc;
    logic [31:0]         r_timer;
    logic [c_addr_w-1:0] r_addr_hold;
    logic [c_data_w-1:0] r_data_hold;
    logic [c_addr_w-1:0] w_addr;
    logic [c_data_w-1:0] w_word;
    logic                w_word_full;
    logic                w_accept;
    logic                w_clear;
    logic                w_start_ok;

    assign w_accept    = byte_valid && (r_state == ST_RECV);
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
    assign w_index_inc = r_index + {{(c_cnt_w-1){1'b0}}, 1'b1};
    // 32-bit wrapping byte address of the current word.
    assign w_addr      = BASE_ADDR + {19'd0, r_index, 2'b00};

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (w_clear),
        .accept    (w_accept),
        .byte_in   (byte_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; clear restarts the assembler on a new load, after
    // each write and when a stalled partial word is abandoned.
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    w_clear = 1'b1;
                    if (word_count == '0)
                        w_next = ST_DONE;
                    else if (32'(word_count) > 32'(MAX_WORDS))
                        w_next = ST_ERR;
                    else
                        w_next = ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_word_full) begin
                    w_next = ST_WRITE;
                end else if (!w_accept && (r_timer == 32'(TIMEOUT))) begin
                    w_next  = ST_ERR;
                    w_clear = 1'b1;
                end
            end
            ST_WRITE: begin
                w_clear = 1'b1;
                if (w_index_inc == r_count) w_next = ST_DONE;
                else                        w_next = ST_RECV;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Load length and word index bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_index <= '0;
        end else if (w_start_ok) begin
            r_count <= word_count;
            r_index <= '0;
        end else if (r_state == ST_WRITE) begin
            r_index <= w_index_inc;
        end
    end

    // Idle counter: runs only on RECV cycles without an accepted byte, so it
    // is zero on entry to RECV and after every accepted byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              r_timer <= '0;
        else if ((r_state == ST_RECV) && !w_accept) r_timer <= r_timer + 32'd1;
        else                                     r_timer <= '0;
    end

    // Remember the last written address/data so the bus holds between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else if (r_state == ST_WRITE) begin
            r_addr_hold <= w_addr;
            r_data_hold <= w_word;
        end
    end

    assign byte_ready = (r_state == ST_RECV);
    assign LDwenable  = (r_state == ST_WRITE);
    assign LDaddress  = (r_state == ST_WRITE) ? w_addr : r_addr_hold;
    assign LDdata     = (r_state == ST_WRITE) ? w_word : r_data_hold;
    assign busy       = (r_state == ST_RECV) || (r_state == ST_WRITE);
    assign cpu_hold   = busy;
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERR);

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Directed self-checking bench for prog_loader. Instance A
//                uses default parameters; instance B uses TIMEOUT=16 and a
//                base address near the top of the address space.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [10:0] word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;

    logic        ready_a, wen_a, hold_a, busy_a, done_a, err_a;
    logic [31:0] addr_a, data_a;
    logic        ready_b, wen_b, hold_b, busy_b, done_b, err_b;
    logic [31:0] addr_b, data_b;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          use_b = 1'b0;
    int          n_done_a = 0;
    logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];

    always #5 clk = ~clk;

    prog_loader dut_a (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(ready_a),
        .LDwenable(wen_a), .LDaddress(addr_a), .LDdata(data_a),
        .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    prog_loader #(.TIMEOUT(16), .BASE_ADDR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(ready_b),
        .LDwenable(wen_b), .LDaddress(addr_b), .LDdata(data_b),
        .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    // Record every write strobe and done pulse.
    always @(negedge clk) begin
        if (wen_a) begin qa_addr.push_back(addr_a); qa_data.push_back(data_a); end
        if (wen_b) begin qb_addr.push_back(addr_b); qb_data.push_back(data_b); end
        if (done_a) n_done_a = n_done_a + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        qa_addr.delete(); qa_data.delete();
        qb_addr.delete(); qb_data.delete();
        n_done_a = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = '0; word_count = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic pulse_start(input logic [10:0] n);
        start = 1'b1;
        word_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = use_b ? ready_b : ready_a;
        end
        check("byte_accept", {31'd0, ok}, 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = use_b ? done_b : done_a;
        end
        check(tag, {31'd0, seen}, 32'd1);
        tick();
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_ready"}, {31'd0, ready_a}, 32'd0);
        check({tag, "_wen"},   {31'd0, wen_a},   32'd0);
        check({tag, "_addr"},  addr_a,           32'd0);
        check({tag, "_data"},  data_a,           32'd0);
        check({tag, "_flags"}, {28'd0, hold_a, busy_a, done_a, err_a}, 32'd0);
    endtask

    task automatic check_wr_a(input string tag, input int idx,
                              input logic [31:0] a, input logic [31:0] d);
        if (qa_addr.size() > idx) begin
            check({tag, "_addr"}, qa_addr[idx], a);
            check({tag, "_data"}, qa_data[idx], d);
        end else begin
            check({tag, "_missing"}, qa_addr.size(), idx + 1);
        end
    endtask

    task automatic check_wr_b(input string tag, input int idx,
                              input logic [31:0] a, input logic [31:0] d);
        if (qb_addr.size() > idx) begin
            check({tag, "_addr"}, qb_addr[idx], a);
            check({tag, "_data"}, qb_data[idx], d);
        end else begin
            check({tag, "_missing"}, qb_addr.size(), idx + 1);
        end
    endtask

    logic [7:0] prog[8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    initial begin
        // ---- reset state and normal two-word load ----
        use_b = 1'b0;
        do_reset();
        check_zero_a("rst");
        pulse_start(11'd2);
        check("t1_busy", {30'd0, busy_a, hold_a}, 32'd3);
        for (int i = 0; i < 8; i++) send_byte(prog[i]);
        wait_done("t1_done");
        check("t1_busy_after", {31'd0, busy_a}, 32'd0);
        check("t1_done_once", n_done_a, 32'd1);
        check("t1_nwrites", qa_addr.size(), 32'd2);
        check_wr_a("t1_w0", 0, 32'h0, 32'h0050_0013);
        check_wr_a("t1_w1", 1, 32'h4, 32'h0010_0093);
        check("t1_hold_addr", addr_a, 32'h4);
        check("t1_hold_data", data_a, 32'h0010_0093);

        // ---- backpressure: 100 idle cycles between bytes ----
        do_reset();
        pulse_start(11'd2);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) repeat (100) tick();
            send_byte(prog[i]);
        end
        wait_done("t2_done");
        check("t2_nwrites", qa_addr.size(), 32'd2);
        check_wr_a("t2_w0", 0, 32'h0, 32'h0050_0013);
        check_wr_a("t2_w1", 1, 32'h4, 32'h0010_0093);
        check("t2_error", {31'd0, err_a}, 32'd0);

        // ---- timeout on instance B, then restart with address wrap ----
        use_b = 1'b1;
        do_reset();
        pulse_start(11'd1);
        send_byte(8'h13);
        send_byte(8'h00);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) check("t3_err_early", {31'd0, err_b}, 32'd0);
            if (k == 17) check("t3_err_17", {31'd0, err_b}, 32'd1);
        end
        check("t3_nwrites", qb_addr.size(), 32'd0);
        check("t3_hold_busy", {30'd0, hold_b, busy_b}, 32'd0);
        pulse_start(11'd2);
        check("t3_err_cleared", {31'd0, err_b}, 32'd0);
        check("t3_restart_busy", {31'd0, busy_b}, 32'd1);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_done("t3_done");
        check("t3_nwrites2", qb_addr.size(), 32'd2);
        check_wr_b("t3_w0", 0, 32'hFFFF_FFFC, 32'h0403_0201);
        check_wr_b("t3_w1", 1, 32'h0000_0000, 32'h0807_0605);

        // ---- boundary lengths ----
        use_b = 1'b0;
        do_reset();
        pulse_start(11'd0);
        check("t4_zero_done", {30'd0, done_a, busy_a}, 32'd2);
        tick();
        check("t4_zero_done_end", {31'd0, done_a}, 32'd0);
        check("t4_zero_nwrites", qa_addr.size(), 32'd0);
        pulse_start(11'd1025);
        check("t4_over_err", {30'd0, err_a, busy_a}, 32'd2);
        pulse_start(11'd1024);
        check("t4_max_accept", {30'd0, err_a, busy_a}, 32'd1);

        // ---- asynchronous reset mid-load ----
        do_reset();
        pulse_start(11'd2);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        check("t5_first_write", qa_addr.size(), 32'd1);
        check_wr_a("t5_w0", 0, 32'h0, 32'hA3A2_A1A0);
        #2;
        reset = 1'b0;
        #1;
        check_zero_a("t5_async");
        tick();
        tick();
        reset = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (10) tick();
        check("t5_ready_idle", {31'd0, ready_a}, 32'd0);
        byte_valid = 1'b0;
        check("t5_no_second", qa_addr.size(), 32'd1);
        pulse_start(11'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        wait_done("t5_done");
        check_wr_a("t5_w1", 1, 32'h0, 32'h1234_5678);

        // ---- start ignored while receiving ----
        do_reset();
        pulse_start(11'd2);
        send_byte(8'h11);
        send_byte(8'h12);
        pulse_start(11'd5);
        for (int i = 3; i <= 8; i++) send_byte(8'h10 + 8'(i));
        wait_done("t6_done");
        check("t6_nwrites", qa_addr.size(), 32'd2);
        check_wr_a("t6_w0", 0, 32'h0, 32'h1413_1211);
        check_wr_a("t6_w1", 1, 32'h4, 32'h1817_1615);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
